// File: rtl/ex_stage_mdu.sv
// Execute stage: ID/EX pipeline register with stall/flush, operand forwarding, ALU,
// and an iterative unsigned multiply/divide unit owning the HI/LO registers.
module ex_stage_mdu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [WIDTH-1:0] id_inA,
    input  logic [WIDTH-1:0] id_inB,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_wmem,
    input  logic             id_aluimm,
    input  logic             id_shift,
    input  logic             id_regrt,
    input  logic [3:0]       id_aluc,
    input  logic [2:0]       id_mdop,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [1:0]       id_fwa,
    input  logic [1:0]       id_fwb,
    input  logic             id_flush,
    input  logic [3:0]       ID_ins_type,
    input  logic [3:0]       ID_ins_number,
    input  logic [WIDTH-1:0] mem_aluR,
    input  logic [WIDTH-1:0] wb_dest,
    output logic             ex_wreg,
    output logic             ex_m2reg,
    output logic             ex_wmem,
    output logic [WIDTH-1:0] ex_aluR,
    output logic [WIDTH-1:0] ex_inB,
    output logic [RADDR-1:0] ex_destR,
    output logic             ex_busy,
    output logic [3:0]       EXE_ins_type,
    output logic [3:0]       EXE_ins_number
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_MFHI  = 3'b011;
    localparam logic [2:0] MD_MFLO  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    typedef struct packed {
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] ina;
        logic [WIDTH-1:0] inb;
        logic             wreg;
        logic             m2reg;
        logic             wmem;
        logic             aluimm;
        logic             shift;
        logic             regrt;
        logic [3:0]       aluc;
        logic [2:0]       mdop;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] rd;
        logic [1:0]       fwa;
        logic [1:0]       fwb;
        logic [3:0]       ins_type;
        logic [3:0]       ins_number;
    } idex_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    idex_t            id_c;
    idex_t            ex_q;
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_c;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_b;
    logic             md_div;
    logic [CW-1:0]    cnt;
    logic             is_md_c;
    logic             md_start_c;
    logic             md_last_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_sh_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] div_sub_c;
    logic [WIDTH-1:0] step_hi_c;
    logic [WIDTH-1:0] step_lo_c;

    // Pack decode-stage fields into the pipeline payload
    always_comb begin
        id_c            = '0;
        id_c.imm        = id_imm;
        id_c.ina        = id_inA;
        id_c.inb        = id_inB;
        id_c.wreg       = id_wreg;
        id_c.m2reg      = id_m2reg;
        id_c.wmem       = id_wmem;
        id_c.aluimm     = id_aluimm;
        id_c.shift      = id_shift;
        id_c.regrt      = id_regrt;
        id_c.aluc       = id_aluc;
        id_c.mdop       = id_mdop;
        id_c.rt         = id_rt;
        id_c.rd         = id_rd;
        id_c.fwa        = id_fwa;
        id_c.fwb        = id_fwb;
        id_c.ins_type   = ID_ins_type;
        id_c.ins_number = ID_ins_number;
    end

    // ID/EX register: stall has priority over flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!ex_busy) begin
            ex_q <= id_flush ? '0 : id_c;
        end
    end

    // Forwarding muxes and ALU
    always_comb begin
        case (ex_q.fwa)
            2'b01:   fwd_a = mem_aluR;
            2'b10:   fwd_a = wb_dest;
            default: fwd_a = ex_q.ina;
        endcase
        case (ex_q.fwb)
            2'b01:   fwd_b = mem_aluR;
            2'b10:   fwd_b = wb_dest;
            default: fwd_b = ex_q.inb;
        endcase
        a_in = ex_q.shift ? WIDTH'(ex_q.imm[10:6]) : fwd_a;
        b_in = ex_q.aluimm ? ex_q.imm : fwd_b;
        sh   = a_in[SHW-1:0];
        case (ex_q.aluc)
            4'b0000: alu_c = a_in + b_in;
            4'b0001: alu_c = a_in - b_in;
            4'b0010: alu_c = a_in & b_in;
            4'b0011: alu_c = a_in | b_in;
            4'b0100: alu_c = a_in ^ b_in;
            4'b0101: alu_c = b_in << sh;
            4'b0110: alu_c = b_in >> sh;
            4'b0111: alu_c = $signed(b_in) >>> sh;
            4'b1000: alu_c = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            4'b1001: alu_c = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            4'b1010: alu_c = b_in << 16;
            default: alu_c = '0;
        endcase
    end

    // MDU state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MDU next state and stall request
    always_comb begin
        state_nxt  = state;
        ex_busy    = 1'b0;
        md_start_c = 1'b0;
        md_last_c  = 1'b0;
        is_md_c    = (ex_q.mdop == MD_MULTU) || (ex_q.mdop == MD_DIVU);
        case (state)
            ST_IDLE: begin
                if (is_md_c) begin
                    ex_busy    = 1'b1;
                    md_start_c = 1'b1;
                    state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                ex_busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    md_last_c = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum_c = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : {(WIDTH+1){1'b0}});
        div_sh_c  = {md_hi, md_lo[WIDTH-1]};
        div_ge_c  = div_sh_c >= {1'b0, md_b};
        div_sub_c = div_sh_c[WIDTH-1:0] - md_b;
        if (md_div) begin
            step_hi_c = div_ge_c ? div_sub_c : div_sh_c[WIDTH-1:0];
            step_lo_c = {md_lo[WIDTH-2:0], div_ge_c};
        end else begin
            step_hi_c = mul_sum_c[WIDTH:1];
            step_lo_c = {mul_sum_c[0], md_lo[WIDTH-1:1]};
        end
    end

    // MDU working registers and architectural HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            md_hi  <= '0;
            md_lo  <= '0;
            md_b   <= '0;
            md_div <= 1'b0;
            cnt    <= '0;
        end else begin
            if (md_start_c) begin
                md_div <= (ex_q.mdop == MD_DIVU);
                md_hi  <= '0;
                md_lo  <= fwd_a;
                md_b   <= fwd_b;
                cnt    <= '0;
            end else if (state == ST_RUN) begin
                md_hi <= step_hi_c;
                md_lo <= step_lo_c;
                cnt   <= cnt + CW'(1);
            end
            if (md_last_c) begin
                hi <= step_hi_c;
                lo <= step_lo_c;
            end else if (!ex_busy && ex_q.mdop == MD_MTHI) begin
                hi <= fwd_a;
            end else if (!ex_busy && ex_q.mdop == MD_MTLO) begin
                lo <= fwd_a;
            end
        end
    end

    always_comb begin
        case (ex_q.mdop)
            MD_MFHI: ex_aluR = hi;
            MD_MFLO: ex_aluR = lo;
            default: ex_aluR = alu_c;
        endcase
    end

    assign ex_inB         = fwd_b;
    assign ex_destR       = ex_q.regrt ? ex_q.rt : ex_q.rd;
    assign ex_wreg        = ex_q.wreg;
    assign ex_m2reg       = ex_q.m2reg;
    assign ex_wmem        = ex_q.wmem;
    assign EXE_ins_type   = ex_q.ins_type;
    assign EXE_ins_number = ex_q.ins_number;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: a 32-bit instance for the main sequence and a
// 16-bit instance for narrow-datapath shift and multiply behaviour.
`timescale 1ns/1ps
module tb_ex_stage_mdu;
    localparam int unsigned W = 32;
    localparam int unsigned H = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] id_imm, id_inA, id_inB, mem_aluR, wb_dest;
    logic         id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_regrt, id_flush;
    logic [3:0]   id_aluc, ID_ins_type, ID_ins_number;
    logic [2:0]   id_mdop;
    logic [4:0]   id_rt, id_rd;
    logic [1:0]   id_fwa, id_fwb;
    logic         ex_wreg, ex_m2reg, ex_wmem, ex_busy;
    logic [W-1:0] ex_aluR, ex_inB;
    logic [4:0]   ex_destR;
    logic [3:0]   EXE_ins_type, EXE_ins_number;

    logic [H-1:0] s_imm, s_inA, s_inB, o16_aluR, o16_inB;
    logic         s_shift;
    logic [3:0]   s_aluc, s_num, o16_type, o16_num;
    logic [2:0]   s_mdop;
    logic         o16_wreg, o16_m2reg, o16_wmem, busy16;
    logic [4:0]   o16_dest;

    ex_stage_mdu #(.WIDTH(W), .RADDR(5), .SHW(5)) u32 (
        .clk(clk), .rst(rst), .id_imm(id_imm), .id_inA(id_inA), .id_inB(id_inB),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluimm(id_aluimm),
        .id_shift(id_shift), .id_regrt(id_regrt), .id_aluc(id_aluc), .id_mdop(id_mdop),
        .id_rt(id_rt), .id_rd(id_rd), .id_fwa(id_fwa), .id_fwb(id_fwb), .id_flush(id_flush),
        .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
        .mem_aluR(mem_aluR), .wb_dest(wb_dest),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_aluR(ex_aluR),
        .ex_inB(ex_inB), .ex_destR(ex_destR), .ex_busy(ex_busy),
        .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number)
    );

    ex_stage_mdu #(.WIDTH(H), .RADDR(5), .SHW(4)) u16 (
        .clk(clk), .rst(rst), .id_imm(s_imm), .id_inA(s_inA), .id_inB(s_inB),
        .id_wreg(1'b0), .id_m2reg(1'b0), .id_wmem(1'b0), .id_aluimm(1'b0),
        .id_shift(s_shift), .id_regrt(1'b0), .id_aluc(s_aluc), .id_mdop(s_mdop),
        .id_rt(5'd0), .id_rd(5'd0), .id_fwa(2'b00), .id_fwb(2'b00), .id_flush(1'b0),
        .ID_ins_type(4'h0), .ID_ins_number(s_num),
        .mem_aluR(16'h0), .wb_dest(16'h0),
        .ex_wreg(o16_wreg), .ex_m2reg(o16_m2reg), .ex_wmem(o16_wmem), .ex_aluR(o16_aluR),
        .ex_inB(o16_inB), .ex_destR(o16_dest), .ex_busy(busy16),
        .EXE_ins_type(o16_type), .EXE_ins_number(o16_num)
    );

    typedef struct {
        logic [3:0]   num;
        logic [3:0]   typ;
        logic [W-1:0] alu;
        logic         chk_alu;
        logic [W-1:0] inb;
        logic         wreg;
        logic         wmem;
        logic [4:0]   dest;
    } exp_t;

    typedef struct {
        logic [3:0]   num;
        logic [H-1:0] alu;
        logic         chk_alu;
    } exp16_t;

    exp_t   q[$];
    exp16_t q16[$];
    int     errors = 0;
    int     checks = 0;
    logic [3:0] nxt = 4'd1;
    logic [3:0] nxt16 = 4'd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        id_imm = '0; id_inA = '0; id_inB = '0; mem_aluR = '0; wb_dest = '0;
        id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_aluimm = 0; id_shift = 0; id_regrt = 0;
        id_flush = 0; id_aluc = '0; id_mdop = '0; id_rt = '0; id_rd = '0;
        id_fwa = '0; id_fwb = '0;
    endtask

    task automatic clr16();
        s_imm = '0; s_inA = '0; s_inB = '0; s_shift = 0; s_aluc = '0; s_mdop = '0;
    endtask

    // Present the instruction, wait for it to be captured, return after the first EX sample
    task automatic issue(input logic [W-1:0] e_alu, input logic c_alu, input logic push);
        exp_t e;
        logic b;
        int   n = 0;
        ID_ins_number = nxt;
        ID_ins_type   = ~nxt;
        nxt = (nxt == 4'd15) ? 4'd1 : nxt + 4'd1;
        e.num = ID_ins_number; e.typ = ID_ins_type; e.alu = e_alu; e.chk_alu = c_alu;
        e.inb = (id_fwb == 2'b01) ? mem_aluR : (id_fwb == 2'b10) ? wb_dest : id_inB;
        e.wreg = id_wreg; e.wmem = id_wmem; e.dest = id_regrt ? id_rt : id_rd;
        if (push && !id_flush) q.push_back(e);
        do begin
            b = ex_busy;
            @(posedge clk); #1;
            n++;
        end while (b && n < 200);
        if (b) chk("issue_timeout", 64'(b), 64'd0);
        @(negedge clk); #1;
    endtask

    task automatic issue16(input logic [H-1:0] e_alu, input logic c_alu);
        exp16_t e;
        logic   b;
        int     n = 0;
        s_num = nxt16;
        nxt16 = (nxt16 == 4'd15) ? 4'd1 : nxt16 + 4'd1;
        e.num = s_num; e.alu = e_alu; e.chk_alu = c_alu;
        q16.push_back(e);
        do begin
            b = busy16;
            @(posedge clk); #1;
            n++;
        end while (b && n < 200);
        if (b) chk("issue16_timeout", 64'(b), 64'd0);
        @(negedge clk); #1;
    endtask

    task automatic wait_idle(input int exp, input logic sel, input string nm);
        int n = 0;
        while ((sel ? busy16 : ex_busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 64'(n), 64'(exp));
    endtask

    // Monitor: a new non-zero tag on a non-stalled cycle is one retired instruction
    initial begin
        exp_t e;
        logic [3:0] last;
        last = '0;
        forever begin
            @(negedge clk);
            if (!rst && !ex_busy) begin
                if (EXE_ins_number != 4'd0 && EXE_ins_number != last) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 64'(EXE_ins_number), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("tag_num", 64'(EXE_ins_number), 64'(e.num));
                        chk("tag_type", 64'(EXE_ins_type), 64'(e.typ));
                        chk("wreg_wmem", {62'd0, ex_wreg, ex_wmem}, {62'd0, e.wreg, e.wmem});
                        chk("destR", 64'(ex_destR), 64'(e.dest));
                        if (e.chk_alu) begin
                            chk("aluR", 64'(ex_aluR), 64'(e.alu));
                            chk("inB", 64'(ex_inB), 64'(e.inb));
                        end
                    end
                end
                last = EXE_ins_number;
            end
        end
    end

    initial begin
        exp16_t e;
        logic [3:0] last;
        last = '0;
        forever begin
            @(negedge clk);
            if (!rst && !busy16) begin
                if (o16_num != 4'd0 && o16_num != last) begin
                    if (q16.size() == 0) begin
                        chk("unexpected_out16", 64'(o16_num), 64'd0);
                    end else begin
                        e = q16.pop_front();
                        chk("tag16", 64'(o16_num), 64'(e.num));
                        if (e.chk_alu) chk("aluR16", 64'(o16_aluR), 64'(e.alu));
                    end
                end
                last = o16_num;
            end
        end
    end

    initial begin
        clr(); clr16(); s_num = '0; ID_ins_number = '0; ID_ins_type = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(ex_busy), 64'd0);
        chk("reset_aluR", 64'(ex_aluR), 64'd0);
        chk("reset_destR", 64'(ex_destR), 64'd0);
        chk("reset_ctrl", {61'd0, ex_wreg, ex_m2reg, ex_wmem}, 64'd0);
        chk("reset_busy16", 64'(busy16), 64'd0);
        rst = 1'b0;

        clr(); id_fwa = 2'b01; mem_aluR = 32'h10; id_fwb = 2'b10; wb_dest = 32'h22;
        id_wreg = 1; id_rd = 5'd5; issue(32'h32, 1, 1);
        clr(); id_inA = 32'd10; id_inB = 32'd3; id_aluc = 4'b0001; issue(32'd7, 1, 1);
        clr(); id_inA = 32'hF0; id_imm = 32'h0F; id_aluimm = 1; id_aluc = 4'b0011;
        id_regrt = 1; id_rt = 5'd9; id_rd = 5'd3; id_wmem = 1; issue(32'hFF, 1, 1);
        clr(); id_inA = 32'hFFFF_FFFF; id_inB = 32'd1; id_aluc = 4'b1000; issue(32'd1, 1, 1);
        clr(); id_inA = 32'hFFFF_FFFF; id_inB = 32'd1; id_aluc = 4'b1001; issue(32'd0, 1, 1);
        clr(); id_imm = 32'h1234; id_aluimm = 1; id_aluc = 4'b1010; issue(32'h1234_0000, 1, 1);
        clr(); id_imm = 32'h100; id_shift = 1; id_inB = 32'd1; id_aluc = 4'b0101; issue(32'h10, 1, 1);
        clr(); id_inA = 32'h5; id_inB = 32'h6; id_aluc = 4'b0100; issue(32'h3, 1, 1);
        clr(); id_inA = 32'h3; id_inB = 32'h5; id_aluc = 4'b1111; issue(32'h0, 1, 1);

        clr(); id_mdop = 3'b001; id_inA = 32'hFFFF_FFFF; id_inB = 32'd2; issue('0, 0, 1);
        wait_idle(W + 1, 0, "multu_busy_cycles");
        clr(); id_mdop = 3'b011; issue(32'h1, 1, 1);
        clr(); id_mdop = 3'b100; issue(32'hFFFF_FFFE, 1, 1);

        clr(); id_mdop = 3'b010; id_inA = 32'd100; id_inB = 32'd7; issue('0, 0, 1);
        wait_idle(W + 1, 0, "divu_busy_cycles");
        clr(); id_mdop = 3'b100; issue(32'd14, 1, 1);
        clr(); id_mdop = 3'b011; issue(32'd2, 1, 1);

        clr(); id_mdop = 3'b010; id_inA = 32'd5; id_inB = 32'd0; issue('0, 0, 1);
        wait_idle(W + 1, 0, "divu0_busy_cycles");
        clr(); id_mdop = 3'b100; issue(32'hFFFF_FFFF, 1, 1);
        clr(); id_mdop = 3'b011; issue(32'd5, 1, 1);

        clr(); id_mdop = 3'b101; id_inA = 32'hABCD; id_aluc = 4'b1111; issue(32'h0, 1, 1);
        clr(); id_mdop = 3'b011; issue(32'hABCD, 1, 1);
        clr(); id_mdop = 3'b110; id_inA = 32'h5A5A; id_aluc = 4'b1111; issue(32'h0, 1, 1);
        clr(); id_mdop = 3'b100; issue(32'h5A5A, 1, 1);

        // Flush while stalled must not disturb the multiply in EX
        clr(); id_mdop = 3'b001; id_inA = 32'd3; id_inB = 32'd5; issue('0, 0, 1);
        id_flush = 1; id_wreg = 1; id_mdop = 3'b000; id_inA = 32'd77;
        repeat (2) begin @(posedge clk); #1; end
        id_flush = 0;
        wait_idle(W - 1, 0, "flush_busy_cycles");
        clr(); id_mdop = 3'b100; issue(32'd15, 1, 1);

        clr(); id_wreg = 1; id_wmem = 1; id_flush = 1; issue('0, 0, 0);
        chk("flush_ctrl", {62'd0, ex_wreg, ex_wmem}, 64'd0);
        chk("flush_type", 64'(EXE_ins_type), 64'd0);
        chk("flush_num", 64'(EXE_ins_number), 64'd0);

        clr(); id_mdop = 3'b001; id_inA = 32'd2; id_inB = 32'd3; issue('0, 0, 1);
        wait_idle(W + 1, 0, "b2b_first_busy");
        clr(); id_mdop = 3'b001; id_inA = 32'd7; id_inB = 32'd8; issue('0, 0, 1);
        wait_idle(W + 1, 0, "b2b_second_busy");
        clr(); id_mdop = 3'b100; issue(32'd56, 1, 1);
        clr(); id_mdop = 3'b011; issue(32'd0, 1, 1);

        // Reset in the middle of a multiply
        clr(); id_mdop = 3'b001; id_inA = 32'd9; id_inB = 32'd9; issue('0, 0, 0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrun_reset_busy", 64'(ex_busy), 64'd0);
        chk("midrun_reset_aluR", 64'(ex_aluR), 64'd0);
        chk("midrun_reset_num", 64'(EXE_ins_number), 64'd0);
        chk("midrun_reset_dest", 64'(ex_destR), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr(); id_mdop = 3'b011; issue(32'd0, 1, 1);
        clr(); id_mdop = 3'b100; issue(32'd0, 1, 1);

        // Narrow datapath
        clr16(); s_inB = 16'h8000; s_imm = 16'h00C0; s_shift = 1; s_aluc = 4'b0111;
        issue16(16'hF000, 1);
        clr16(); s_mdop = 3'b001; s_inA = 16'h1234; s_inB = 16'h0010; issue16('0, 0);
        wait_idle(H + 1, 1, "multu16_busy_cycles");
        clr16(); s_mdop = 3'b011; issue16(16'h0001, 1);
        clr16(); s_mdop = 3'b100; issue16(16'h2340, 1);
        clr16(); s_num = 4'd0;

        clr(); ID_ins_number = '0;
        for (int i = 0; i < 20 && (q.size() != 0 || q16.size() != 0); i++) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size() + q16.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage for the pipelined MIPS core. It owns the ID/EX pipeline register, with stall and flush, and adds operand forwarding muxes, the ALU, and an iterative unsigned multiply/divide unit with HI/LO registers. It sits between the decode stage and the EX/MEM register. While a multiply or divide is in progress it raises `ex_busy` to freeze the front of the pipe.

## Interface
Parameters:
- `WIDTH`, 32, datapath width (power of two, ≥8)
- `RADDR`, 5, register-address width
- `SHW`, 5, shift-amount width (= log2 WIDTH)

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `id_imm`, `id_inA`, `id_inB`  in  WIDTH  immediate and register operands from ID.
- `id_wreg`, `id_m2reg`, `id_wmem`, `id_aluimm`, `id_shift`, `id_regrt`  in  1  control bits, same meaning as the current EX stage.
- `id_aluc`  in  4  ALU opcode.
- `id_mdop`  in  3  MDU op: 000 none, 001 MULTU, 010 DIVU, 011 MFHI, 100 MFLO, 101 MTHI, 110 MTLO, 111 none.
- `id_rt`, `id_rd`  in  RADDR  destination candidates.
- `id_fwa`, `id_fwb`  in  2  forward selects: 00 register, 01 `mem_aluR`, 10 `wb_dest`, 11 register.
- `id_flush`  in  1  load a bubble instead of the ID instruction.
- `ID_ins_type`, `ID_ins_number`  in  4  debug tags.
- `mem_aluR`, `wb_dest`  in  WIDTH  forwarding sources, sampled combinationally.
- `ex_wreg`, `ex_m2reg`, `ex_wmem`  out  1  registered control.
- `ex_aluR`  out  WIDTH  result.
- `ex_inB`  out  WIDTH  forwarded B operand, used as store data.
- `ex_destR`  out  RADDR  destination: `rt` if regrt, else `rd`.
- `ex_busy`  out  1  stall request to IF/ID.
- `EXE_ins_type`, `EXE_ins_number`  out  4  registered debug tags.

## Operation
- **ID/EX register.** All `id_*` inputs, the forward selects and the tags are captured on each rising edge where `ex_busy`=0.
  - If `id_flush`=1 on that edge, a bubble is loaded: every field 0.
  - If `ex_busy`=1, the register holds its value and `id_flush` is ignored. Upstream keeps the flush asserted while stalled.
- **Forwarding.**
  - A = select(`fwa`, edata_a, `mem_aluR`, `wb_dest`); B likewise with `fwb`.
  - `ex_inB` = forwarded B.
- **ALU operand selection.**
  - a_in = shift ? zero-extended imm[10:6] : A.
  - b_in = aluimm ? imm : B.
- **ALU ops by aluc.**
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra: shift b_in by a_in[SHW-1:0].
  - 1000 slt (signed), 1001 sltu, 1010 lui (b_in << 16).
  - All other codes produce 0. Arithmetic wraps modulo 2^WIDTH.
- **ex_aluR.** HI for MFHI, LO for MFLO, otherwise the ALU result.
- **MTHI/MTLO.** Write A into HI/LO on the edge at which the instruction leaves EX, meaning the next edge with `ex_busy`=0.
- **MDU FSM.** States IDLE, RUN, DONE.
  - IDLE: if the latched mdop is MULTU or DIVU, `ex_busy`=1. Next edge: load A and B, clear the counter, go to RUN.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide), `ex_busy`=1. After WIDTH steps, write the results to HI/LO and go to DONE.
  - DONE: `ex_busy`=0. The next edge loads the next instruction and returns to IDLE.
- **Results.**
  - MULTU: {HI,LO} = A×B, 2·WIDTH bits.
  - DIVU: LO = A/B, HI = A%B.
  - DIVU with B=0: LO = all ones, HI = A. The full latency still applies.
- **Control during MULTU/DIVU.** The decoder drives wreg=0 and wmem=0, and the stage does not override this.
- **Reset.**
  - All ID/EX fields are 0, so all outputs are 0 and `ex_destR`=0.
  - HI=0, LO=0, FSM=IDLE, `ex_busy`=0.
  - Reset during RUN aborts the operation. HI/LO are cleared and not partially written.

## Timing
- ALU path: one cycle. Inputs latched at edge t give `ex_aluR` valid after edge t, combinationally from the latched fields and the forwarding inputs.
- MULTU/DIVU: `ex_busy` high for exactly WIDTH+1 cycles (1 IDLE + WIDTH RUN).
  - HI/LO are updated at the edge ending the last RUN cycle.
  - The following instruction enters EX one edge later. An MFHI/MFLO there sees the new value.
- Back-to-back MULTU: the second enters EX at the DONE→IDLE edge and starts immediately. Total 2·(WIDTH+2) cycles.
- MTHI followed by MFHI: MFHI reads the new HI with no stall.
- Flush and stall on the same edge: the stall wins, and the register holds.

## Test plan
- Reset mid-RUN (WIDTH=32) → all outputs 0, `ex_busy`=0, HI=LO=0.
- `add` with fwa=01, `mem_aluR`=0x10, fwb=10, `wb_dest`=0x22 → `ex_aluR`=0x32 and `ex_inB`=0x22 one cycle after capture.
- MULTU A=0xFFFFFFFF, B=2 → `ex_busy` high for 33 cycles. Then MFHI → 0x1, MFLO → 0xFFFFFFFE.
- DIVU A=100, B=7 → LO=14, HI=2. DIVU A=5, B=0 → LO=0xFFFFFFFF, HI=5, latency unchanged.
- `id_flush` pulsed while `ex_busy`=1 → held instruction unchanged. Same pulse when not busy → `ex_wreg`=`ex_wmem`=0 and tags=0.
- WIDTH=16 build: sra of 0x8000 by 3 → 0xF000. MULTU 0x1234×0x10 → {HI,LO}=0x0001_2340. Busy for 17 cycles.
